// File: rtl/noc_pkg.sv
// Shared NoC definitions: the flit layout, flit type codes and address field helpers.
package noc_pkg;

  localparam logic [2:0] FLIT_HEAD   = 3'b000;
  localparam logic [2:0] FLIT_BODY   = 3'b001;
  localparam logic [2:0] FLIT_TAIL   = 3'b010;
  localparam logic [2:0] FLIT_IDLE   = 3'b011;
  localparam logic [2:0] FLIT_SINGLE = 3'b100;

  localparam logic [31:0] IDLE_FLIT = 32'h6000_0000;

  typedef struct packed {
    logic [2:0]  ftype;
    logic [1:0]  vc;
    logic [26:0] payload;
  } flit_t;

  function automatic logic [3:0] addr_row(input logic [7:0] addr);
    return addr[7:4];
  endfunction

  function automatic logic [3:0] addr_col(input logic [7:0] addr);
    return addr[3:0];
  endfunction

  function automatic flit_t make_flit(input logic [2:0] ftype, input logic [1:0] vc,
                                      input logic [26:0] payload);
    flit_t f;
    f.ftype   = ftype;
    f.vc      = vc;
    f.payload = payload;
    return f;
  endfunction

endpackage

// File: rtl/noc_packetizer_if.sv
// Core-side descriptor/payload handshakes plus the router-facing flit and full flags.
interface noc_packetizer_if;
  logic        msg_valid;
  logic        msg_ready;
  logic [7:0]  msg_dest;
  logic [3:0]  msg_len;
  logic [1:0]  msg_vc;
  logic        pl_valid;
  logic        pl_ready;
  logic [26:0] pl_data;
  logic [3:0]  full_in_vc;
  logic [31:0] flit_out;

  // master: the core and router environment; slave: the packetizer itself
  modport master (
    output msg_valid, msg_dest, msg_len, msg_vc, pl_valid, pl_data, full_in_vc,
    input  msg_ready, pl_ready, flit_out
  );

  modport slave (
    input  msg_valid, msg_dest, msg_len, msg_vc, pl_valid, pl_data, full_in_vc,
    output msg_ready, pl_ready, flit_out
  );
endinterface

// File: rtl/noc_packetizer.sv
// Serialises core message descriptors and payload words into head/body/tail flits
// for the router core input, honouring per-VC full back-pressure.
module noc_packetizer
  import noc_pkg::*;
#(
    parameter int M       = 2,
    parameter int N       = 2,
    parameter int MAX_LEN = 8
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic [7:0]              current_address,
    noc_packetizer_if.slave         bus,
    output logic                    err_drop,
    output logic [15:0]             pkt_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HEAD = 2'd1;
    localparam logic [1:0] S_BODY = 2'd2;
    localparam logic [1:0] S_DROP = 2'd3;

    localparam logic [3:0] LEN_CAP = MAX_LEN[3:0];
    localparam logic [4:0] ROWS    = M[4:0];
    localparam logic [4:0] COLS    = N[4:0];

    logic [1:0]  state;
    logic [7:0]  dest;
    logic [3:0]  len;
    logic [1:0]  vc;
    logic [3:0]  remaining;

    logic        vc_full;
    logic        pl_fire;
    logic        dest_ok;
    logic [3:0]  len_clamped;
    logic [26:0] head_payload;

    assign vc_full      = bus.full_in_vc[vc];
    assign dest_ok      = ({1'b0, addr_row(bus.msg_dest)} < ROWS) &&
                          ({1'b0, addr_col(bus.msg_dest)} < COLS);
    assign len_clamped  = (bus.msg_len > LEN_CAP) ? LEN_CAP : bus.msg_len;
    assign head_payload = {7'd0, len, dest, current_address};

    // Ready is masked by clr so nothing is taken while the block is held in reset.
    assign bus.msg_ready = (state == S_IDLE) && !clr;
    assign bus.pl_ready  = (state == S_BODY) && !vc_full;
    assign pl_fire       = bus.pl_valid && bus.pl_ready;
    assign err_drop      = (state == S_DROP);

    // NOTE: every register here is updated with <= so all of them see pre-edge values.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state     <= S_IDLE;
            dest      <= '0;
            len       <= '0;
            vc        <= '0;
            remaining <= '0;
            flit_out_reset();
            pkt_count <= '0;
        end else begin
            bus.flit_out <= IDLE_FLIT;
            case (state)
                S_IDLE: begin
                    if (bus.msg_valid) begin
                        dest  <= bus.msg_dest;
                        len   <= len_clamped;
                        vc    <= bus.msg_vc;
                        state <= dest_ok ? S_HEAD : S_DROP;
                    end
                end
                S_HEAD: begin
                    if (!vc_full) begin
                        if (len == 4'd0) begin
                            bus.flit_out <= make_flit(FLIT_SINGLE, vc, head_payload);
                            pkt_count    <= pkt_count + 16'd1;
                            state        <= S_IDLE;
                        end else begin
                            bus.flit_out <= make_flit(FLIT_HEAD, vc, head_payload);
                            remaining    <= len;
                            state        <= S_BODY;
                        end
                    end
                end
                S_BODY: begin
                    if (pl_fire) begin
                        bus.flit_out <= make_flit((remaining == 4'd1) ? FLIT_TAIL : FLIT_BODY,
                                                  vc, bus.pl_data);
                        remaining    <= remaining - 4'd1;
                        if (remaining == 4'd1) begin
                            pkt_count <= pkt_count + 16'd1;
                            state     <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // The async clear drives the idle flit straight onto the link.
    task automatic flit_out_reset();
        bus.flit_out <= IDLE_FLIT;
    endtask

endmodule

// File: tb/tb_noc_packetizer.sv
// Directed bench for noc_packetizer: hand-computed flits, back-pressure, drop, clamp, reset, wrap.
module tb_noc_packetizer;
    import noc_pkg::*;

    logic        clk;
    logic        clr;
    logic [7:0]  current_address;
    logic        err_drop;
    logic [15:0] pkt_count;

    int n_checks = 0;
    int n_pass   = 0;

    noc_packetizer_if bus ();

    noc_packetizer #(.M(2), .N(2), .MAX_LEN(8)) dut (
        .clk             (clk),
        .clr             (clr),
        .current_address (current_address),
        .bus             (bus.slave),
        .err_drop        (err_drop),
        .pkt_count       (pkt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic cycle();
        @(negedge clk);
    endtask

    task automatic drive_msg(input logic [7:0] dest, input logic [3:0] len, input logic [1:0] vc);
        bus.msg_valid = 1'b1;
        bus.msg_dest  = dest;
        bus.msg_len   = len;
        bus.msg_vc    = vc;
    endtask

    // Head-only packet: accept, one HEAD cycle, then back to idle.
    task automatic send_single(input string tag, input logic [7:0] dest, input logic [1:0] vc,
                               input logic [31:0] exp_flit, input logic [15:0] exp_count);
        drive_msg(dest, 4'd0, vc);
        cycle();
        bus.msg_valid = 1'b0;
        check({tag, "_ready_busy"}, {31'd0, bus.msg_ready}, 32'd0);
        cycle();
        check({tag, "_flit"}, bus.flit_out, exp_flit);
        check({tag, "_count"}, {16'd0, pkt_count}, {16'd0, exp_count});
        cycle();
        check({tag, "_idle_after"}, bus.flit_out, 32'h6000_0000);
    endtask

    initial begin
        clr             = 1'b1;
        current_address = 8'h00;
        bus.msg_valid   = 1'b0;
        bus.msg_dest    = 8'h00;
        bus.msg_len     = 4'd0;
        bus.msg_vc      = 2'd0;
        bus.pl_valid    = 1'b0;
        bus.pl_data     = 27'd0;
        bus.full_in_vc  = 4'd0;

        // Reset state
        cycle();
        cycle();
        check("rst_flit", bus.flit_out, 32'h6000_0000);
        check("rst_msg_ready", {31'd0, bus.msg_ready}, 32'd0);
        check("rst_count", {16'd0, pkt_count}, 32'd0);
        check("rst_err", {31'd0, err_drop}, 32'd0);
        clr = 1'b0;
        cycle();
        check("rel_msg_ready", {31'd0, bus.msg_ready}, 32'd1);
        check("rel_pl_ready", {31'd0, bus.pl_ready}, 32'd0);

        // Basic 2-word packet to 8'h11 on VC1
        drive_msg(8'h11, 4'd2, 2'd1);
        cycle();
        bus.msg_valid = 1'b0;
        bus.pl_valid  = 1'b1;
        bus.pl_data   = 27'h1;
        check("p1_idle_accept", bus.flit_out, 32'h6000_0000);
        check("p1_pl_ready_head", {31'd0, bus.pl_ready}, 32'd0);
        cycle();
        check("p1_head", bus.flit_out, 32'h0802_1100);
        cycle();
        check("p1_body", bus.flit_out, 32'h2800_0001);
        bus.pl_data = 27'h2;
        cycle();
        check("p1_tail", bus.flit_out, 32'h4800_0002);
        check("p1_count", {16'd0, pkt_count}, 32'd1);
        check("p1_ready_after", {31'd0, bus.msg_ready}, 32'd1);
        bus.pl_valid = 1'b0;
        cycle();
        check("p1_idle_after", bus.flit_out, 32'h6000_0000);

        // Single flit, and a packet addressed to ourselves
        send_single("single", 8'h01, 2'd0, 32'h8000_0100, 16'd2);
        send_single("self", 8'h00, 2'd2, 32'h9000_0000, 16'd3);

        // Back-pressure on VC1 for 4 cycles during BODY
        drive_msg(8'h11, 4'd2, 2'd1);
        cycle();
        bus.msg_valid = 1'b0;
        bus.pl_valid  = 1'b1;
        bus.pl_data   = 27'h1;
        cycle();
        check("bp_head", bus.flit_out, 32'h0802_1100);
        bus.full_in_vc = 4'b0010;
        #1;
        check("bp_pl_ready_full", {31'd0, bus.pl_ready}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            cycle();
            check($sformatf("bp_stall%0d", i), bus.flit_out, 32'h6000_0000);
        end
        bus.full_in_vc = 4'b0000;
        cycle();
        check("bp_body", bus.flit_out, 32'h2800_0001);
        bus.pl_data = 27'h2;
        cycle();
        check("bp_tail", bus.flit_out, 32'h4800_0002);
        check("bp_count", {16'd0, pkt_count}, 32'd4);
        bus.pl_valid = 1'b0;
        cycle();

        // Out-of-mesh destination is dropped
        drive_msg(8'h23, 4'd2, 2'd0);
        cycle();
        bus.msg_valid = 1'b0;
        bus.pl_valid  = 1'b1;
        bus.pl_data   = 27'h7;
        #1;
        check("drop_err", {31'd0, err_drop}, 32'd1);
        check("drop_flit", bus.flit_out, 32'h6000_0000);
        check("drop_pl_ready", {31'd0, bus.pl_ready}, 32'd0);
        cycle();
        check("drop_err_clear", {31'd0, err_drop}, 32'd0);
        check("drop_flit2", bus.flit_out, 32'h6000_0000);
        check("drop_ready", {31'd0, bus.msg_ready}, 32'd1);
        check("drop_pl_ready2", {31'd0, bus.pl_ready}, 32'd0);
        check("drop_count", {16'd0, pkt_count}, 32'd4);
        bus.pl_valid = 1'b0;

        // Length 12 clamps to 8
        drive_msg(8'h01, 4'd12, 2'd3);
        cycle();
        bus.msg_valid = 1'b0;
        bus.pl_valid  = 1'b1;
        bus.pl_data   = 27'd1;
        cycle();
        check("clamp_head", bus.flit_out, 32'h1808_0100);
        for (int i = 1; i <= 8; i++) begin
            cycle();
            check($sformatf("clamp_word%0d", i), bus.flit_out,
                  (i == 8) ? 32'h5800_0008 : (32'h3800_0000 | i));
            bus.pl_data = 27'(i + 1);
        end
        check("clamp_count", {16'd0, pkt_count}, 32'd5);
        bus.pl_valid = 1'b0;
        cycle();
        check("clamp_idle_after", bus.flit_out, 32'h6000_0000);

        // Reset mid-packet, held 3 cycles
        drive_msg(8'h11, 4'd2, 2'd1);
        cycle();
        bus.msg_valid = 1'b0;
        bus.pl_valid  = 1'b1;
        bus.pl_data   = 27'h1;
        cycle();
        check("mid_head", bus.flit_out, 32'h0802_1100);
        clr = 1'b1;
        #1;
        check("mid_clr_flit", bus.flit_out, 32'h6000_0000);
        check("mid_clr_count", {16'd0, pkt_count}, 32'd0);
        check("mid_clr_ready", {31'd0, bus.msg_ready}, 32'd0);
        cycle();
        cycle();
        cycle();
        clr          = 1'b0;
        bus.pl_valid = 1'b0;
        #1;
        check("mid_rel_ready", {31'd0, bus.msg_ready}, 32'd1);
        cycle();
        check("mid_rel_flit", bus.flit_out, 32'h6000_0000);
        check("mid_rel_pl_ready", {31'd0, bus.pl_ready}, 32'd0);

        // Counter wrap
        force dut.pkt_count = 16'hFFFF;
        cycle();
        release dut.pkt_count;
        #1;
        check("wrap_preset", {16'd0, pkt_count}, 32'h0000_FFFF);
        send_single("wrap", 8'h10, 2'd1, 32'h8800_1000, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
